// File: rtl/clk_gen_sequencer.sv
// Configuration sequencer driving the two-phase clock generator's go/datain load protocol.
// Optional mid-run reload (accept a new config while running) is enabled by CLK_GEN_SEQ_RELOAD_EN.
module clk_gen_sequencer #(
    parameter int unsigned RUN_W      = 8,
    parameter int          GAP_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [2:0]       cfg_duty_i,
    input  logic [2:0]       cfg_phase_i,
    input  logic [RUN_W-1:0] cfg_cycles_i,
    input  logic             stop_i,
    output logic             go_o,
    output logic [2:0]       datain_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int GapEff = (GAP_CYCLES < 1) ? 1 : ((GAP_CYCLES > 15) ? 15 : GAP_CYCLES);
    localparam logic [3:0] GapLast = 4'(GapEff - 1);
    localparam logic [RUN_W-1:0] RunMax = '1;

    typedef enum logic [2:0] {StIdle, StLoadDuty, StLoadPhase, StRun, StGap} state_e;

    state_e           state_q;
    logic             go_q, busy_q, done_q;
    logic [2:0]       datain_q, phase_q;
    logic [RUN_W-1:0] cycles_q, run_cnt_q;
    logic [3:0]       gap_cnt_q;
    logic             accept, run_last, to_gap;

`ifdef CLK_GEN_SEQ_RELOAD_EN
    logic             pend_q;
    logic [2:0]       pend_duty_q, pend_phase_q;
    logic [RUN_W-1:0] pend_cycles_q;

    assign cfg_ready_o = ((state_q == StIdle) || ((state_q == StRun) && !pend_q)) && !stop_i;
`else
    assign cfg_ready_o = (state_q == StIdle) && !stop_i;
`endif

    assign accept   = cfg_valid_i && cfg_ready_o;
    assign run_last = (cycles_q != '0) && (run_cnt_q == cycles_q - RUN_W'(1));
    // Any loading/running state aborts to GAP on stop; RUN also ends on count or reload accept.
    assign to_gap   = ((state_q == StLoadDuty || state_q == StLoadPhase) && stop_i)
                   || ((state_q == StRun) && (stop_i || run_last || accept));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            go_q      <= 1'b0;
            datain_q  <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            phase_q   <= 3'd0;
            cycles_q  <= '0;
            run_cnt_q <= '0;
            gap_cnt_q <= 4'd0;
`ifdef CLK_GEN_SEQ_RELOAD_EN
            pend_q        <= 1'b0;
            pend_duty_q   <= 3'd0;
            pend_phase_q  <= 3'd0;
            pend_cycles_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (to_gap) begin
                state_q   <= StGap;
                go_q      <= 1'b0;
                datain_q  <= 3'd0;
                gap_cnt_q <= 4'd0;
`ifdef CLK_GEN_SEQ_RELOAD_EN
                if (accept) begin
                    pend_q        <= 1'b1;
                    pend_duty_q   <= cfg_duty_i;
                    pend_phase_q  <= cfg_phase_i;
                    pend_cycles_q <= cfg_cycles_i;
                end
`endif
            end else begin
                case (state_q)
                    StIdle: begin
                        if (accept) begin
                            state_q  <= StLoadDuty;
                            go_q     <= 1'b1;
                            datain_q <= cfg_duty_i;
                            busy_q   <= 1'b1;
                            phase_q  <= cfg_phase_i;
                            cycles_q <= cfg_cycles_i;
                        end
                    end
                    StLoadDuty: begin
                        state_q  <= StLoadPhase;
                        datain_q <= phase_q;
                    end
                    StLoadPhase: begin
                        state_q   <= StRun;
                        run_cnt_q <= '0;
                    end
                    StRun: begin
                        // Saturate so a continuous run never wraps.
                        if (run_cnt_q != RunMax) run_cnt_q <= run_cnt_q + RUN_W'(1);
                    end
                    StGap: begin
`ifdef CLK_GEN_SEQ_RELOAD_EN
                        if (stop_i) pend_q <= 1'b0;
                        if (gap_cnt_q == GapLast && pend_q && !stop_i) begin
                            state_q  <= StLoadDuty;
                            go_q     <= 1'b1;
                            datain_q <= pend_duty_q;
                            phase_q  <= pend_phase_q;
                            cycles_q <= pend_cycles_q;
                            pend_q   <= 1'b0;
                        end else
`endif
                        if (gap_cnt_q == GapLast) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 4'd1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign go_o     = go_q;
    assign datain_o = datain_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_clk_gen_sequencer.sv
// Directed bench for clk_gen_sequencer: per-cycle expected {ready,busy,go,datain,done}
// vectors are queued with each stimulus step and compared after every clock edge.
module tb_clk_gen_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid, cfg_ready, stop, go, busy, done;
    logic [2:0] cfg_duty, cfg_phase, datain;
    logic [7:0] cfg_cycles;

`ifdef CLK_GEN_SEQ_RELOAD_EN
    localparam logic RunRdy = 1'b1;
`else
    localparam logic RunRdy = 1'b0;
`endif

    typedef logic [6:0] vec_t;
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    clk_gen_sequencer #(.RUN_W(8), .GAP_CYCLES(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_duty_i  (cfg_duty),
        .cfg_phase_i (cfg_phase),
        .cfg_cycles_i(cfg_cycles),
        .stop_i      (stop),
        .go_o        (go),
        .datain_o    (datain),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    function automatic vec_t obs();
        return {cfg_ready, busy, go, datain, done};
    endfunction

    task automatic check(input string tag, input vec_t o, input vec_t e);
        n_checks++;
        assert (o === e) n_pass++;
        else $error("FAIL %s observed=%b expected=%b (ready,busy,go,datain,done)", tag, o, e);
    endtask

    task automatic ex(input logic r, input logic b, input logic g, input logic [2:0] d,
                      input logic dn);
        exp_q.push_back({r, b, g, d, dn});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) check(tag, obs(), exp_q.pop_front());
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) step(tag);
    endtask

    task automatic offer(input logic [2:0] d, input logic [2:0] p, input logic [7:0] c);
        cfg_valid  = 1'b1;
        cfg_duty   = d;
        cfg_phase  = p;
        cfg_cycles = c;
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; cfg_valid = 1'b0; cfg_duty = 3'd0; cfg_phase = 3'd0;
        cfg_cycles = 8'd0; stop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        v = obs();
        check("reset_state", {1'b0, v[5:0]}, 7'b0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", obs(), 7'b1000000);

        // Finite run: 2 + 4 go-high cycles, 2-cycle gap, done.
        offer(3'd3, 3'd2, 8'd4);
        ex(0, 1, 1, 3'd3, 0);
        step("t1_accept");
        cfg_valid = 1'b0;
        ex(0, 1, 1, 3'd2, 0);
        repeat (4) ex(RunRdy, 1, 1, 3'd2, 0);
        ex(0, 1, 0, 3'd0, 0);
        ex(0, 1, 0, 3'd0, 0);
        ex(1, 0, 0, 3'd0, 1);
        ex(1, 0, 0, 3'd0, 0);
        drain("t1_run");

        // Continuous run stopped 20 cycles after accept.
        offer(3'd5, 3'd1, 8'd0);
        ex(0, 1, 1, 3'd5, 0);
        step("t2_accept");
        cfg_valid = 1'b0;
        ex(0, 1, 1, 3'd1, 0);
        repeat (18) ex(RunRdy, 1, 1, 3'd1, 0);
        drain("t2_run");
        stop = 1'b1;
        ex(0, 1, 0, 3'd0, 0);
        drain("t2_stop");
        stop = 1'b0;
        ex(0, 1, 0, 3'd0, 0);
        ex(1, 0, 0, 3'd0, 1);
        ex(1, 0, 0, 3'd0, 0);
        drain("t2_gap");

        // Stop during LOAD_DUTY: go high for exactly one cycle.
        offer(3'd7, 3'd5, 8'd4);
        ex(0, 1, 1, 3'd7, 0);
        step("t3_accept");
        cfg_valid = 1'b0;
        stop = 1'b1;
        ex(0, 1, 0, 3'd0, 0);
        step("t3_stop");
        stop = 1'b0;
        ex(0, 1, 0, 3'd0, 0);
        ex(1, 0, 0, 3'd0, 1);
        drain("t3_gap");

`ifndef CLK_GEN_SEQ_RELOAD_EN
        // cfg_valid held through a run: second request only accepted from IDLE.
        offer(3'd1, 3'd2, 8'd1);
        ex(0, 1, 1, 3'd1, 0);
        ex(0, 1, 1, 3'd2, 0);
        ex(0, 1, 1, 3'd2, 0);
        ex(0, 1, 0, 3'd0, 0);
        ex(0, 1, 0, 3'd0, 0);
        ex(1, 0, 0, 3'd0, 1);
        ex(0, 1, 1, 3'd1, 0);
        drain("t4_held");
        cfg_valid = 1'b0;
        ex(0, 1, 1, 3'd2, 0);
        ex(0, 1, 1, 3'd2, 0);
        ex(0, 1, 0, 3'd0, 0);
        ex(0, 1, 0, 3'd0, 0);
        ex(1, 0, 0, 3'd0, 1);
        ex(1, 0, 0, 3'd0, 0);
        drain("t4_second");
`endif

        // Asynchronous reset in the middle of a run.
        offer(3'd6, 3'd4, 8'd0);
        ex(0, 1, 1, 3'd6, 0);
        step("t5_accept");
        cfg_valid = 1'b0;
        ex(0, 1, 1, 3'd4, 0);
        ex(RunRdy, 1, 1, 3'd4, 0);
        ex(RunRdy, 1, 1, 3'd4, 0);
        drain("t5_run");
        rst = 1'b1;
        #1;
        v = obs();
        check("t5_async_reset", {1'b0, v[5:0]}, 7'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t5_after_reset", obs(), 7'b1000000);
        offer(3'd2, 3'd3, 8'd2);
        ex(0, 1, 1, 3'd2, 0);
        step("t5_reaccept");
        cfg_valid = 1'b0;
        ex(0, 1, 1, 3'd3, 0);
        ex(RunRdy, 1, 1, 3'd3, 0);
        ex(RunRdy, 1, 1, 3'd3, 0);
        ex(0, 1, 0, 3'd0, 0);
        ex(0, 1, 0, 3'd0, 0);
        ex(1, 0, 0, 3'd0, 1);
        ex(1, 0, 0, 3'd0, 0);
        drain("t5_rerun");

`ifdef CLK_GEN_SEQ_RELOAD_EN
        // Reload while running: gap then new load, no done between runs.
        offer(3'd2, 3'd1, 8'd0);
        ex(0, 1, 1, 3'd2, 0);
        step("t6_accept");
        cfg_valid = 1'b0;
        ex(0, 1, 1, 3'd1, 0);
        ex(1, 1, 1, 3'd1, 0);
        ex(1, 1, 1, 3'd1, 0);
        drain("t6_run");
        offer(3'd4, 3'd3, 8'd0);
        ex(0, 1, 0, 3'd0, 0);
        step("t6_reload");
        cfg_valid = 1'b0;
        ex(0, 1, 0, 3'd0, 0);
        ex(0, 1, 1, 3'd4, 0);
        ex(0, 1, 1, 3'd3, 0);
        ex(1, 1, 1, 3'd3, 0);
        drain("t6_second");
        stop = 1'b1;
        ex(0, 1, 0, 3'd0, 0);
        step("t6_stop");
        stop = 1'b0;
        ex(0, 1, 0, 3'd0, 0);
        ex(1, 0, 0, 3'd0, 1);
        drain("t6_gap");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
